// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: runs one load/store on a req/ack bus, aligns loads for the MDR.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN (adds the TIMEOUT_CYCLES parameter).
module mem_access_unit #(
    parameter int BUS_WIDTH = 32
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mem_write,
    input  logic [2:0]             funct3,
    input  logic [BUS_WIDTH-1:0]   addr,
    input  logic [BUS_WIDTH-1:0]   store_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [BUS_WIDTH-1:0]   load_data,
    output logic                   load_mdr,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [BUS_WIDTH-1:0]   bus_addr,
    output logic [BUS_WIDTH/8-1:0] bus_be,
    output logic [BUS_WIDTH-1:0]   bus_wdata,
    input  logic [BUS_WIDTH-1:0]   bus_rdata,
    input  logic                   bus_ack
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;
    logic [2:0]             f3_q, f3_d;
    logic [BUS_WIDTH-1:0]   addr_q, addr_d;
    logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BUS_WIDTH/8-1:0] be_q, be_d;
    logic [BUS_WIDTH-1:0]   load_data_q, load_data_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic                   legal;
    logic [BUS_WIDTH/8-1:0] be_start;
    logic [BUS_WIDTH-1:0]   wdata_start;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic [BUS_WIDTH-1:0]   rd_ext;

    // Decode of the incoming request, plus extraction of the returned word.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~mem_write;
            3'b101:  legal = ~mem_write & ~addr[0];
            default: legal = 1'b0;
        endcase

        case (funct3[1:0])
            2'b00: begin
                be_start    = 4'b0001 << addr[1:0];
                wdata_start = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_start    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_start = {2{store_data[15:0]}};
            end
            default: begin
                be_start    = 4'b1111;
                wdata_start = store_data;
            end
        endcase

        rd_byte = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = bus_rdata[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'h000000, rd_byte};
            3'b101:  rd_ext = {16'h0000, rd_half};
            default: rd_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        err_d       = err_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        load_data_d = load_data_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    we_d    = mem_write;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata_start;
                    be_d    = be_start;
                    err_d   = ~legal;
                    state_d = legal ? S_ACCESS : S_DONE;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_ACCESS: begin
                // Ack is checked first so an ack in the last allowed cycle beats the timeout.
                if (bus_ack) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    if (!we_q) load_data_d = rd_ext;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            load_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            err_q       <= err_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            load_data_q <= load_data_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Bus fields are presented only while the request is up.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = done & err_q;
    assign load_mdr  = done & ~we_q & ~err_q;
    assign load_data = load_data_q;
    assign bus_req   = (state_q == S_ACCESS);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[BUS_WIDTH-1:2], 2'b00} : '0;
    assign bus_be    = bus_req ? be_q : '0;
    assign bus_wdata = bus_req ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; timeout cases run when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] load_data;
    logic        load_mdr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

`ifdef MEM_TIMEOUT_EN
    mem_access_unit #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
`else
    mem_access_unit #(.BUS_WIDTH(32)) dut (
`endif
        .clk(clk), .rst(rst), .start(start), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .error(error), .load_data(load_data),
        .load_mdr(load_mdr), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns in the cycle after the edge that sampled start.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        start = 1'b1; mem_write = we; funct3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Holds ack low for 'waits' request cycles, then acks; returns in the DONE cycle.
    task automatic complete(input int unsigned waits, input logic [31:0] rd);
        for (int unsigned i = 0; i < waits; i++) begin
            check("req_hold", 32'(bus_req), 1);
            @(negedge clk);
        end
        bus_ack = 1'b1; bus_rdata = rd;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rd, input logic [3:0] exp_be, input logic [31:0] exp_ld);
        issue(1'b0, f3, a, 32'h0);
        check({tag, "_be"}, 32'(bus_be), 32'(exp_be));
        check({tag, "_we"}, 32'(bus_we), 0);
        complete(0, rd);
        check({tag, "_mdr"}, 32'(load_mdr), 1);
        check({tag, "_data"}, load_data, exp_ld);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0; bus_rdata = '0; bus_ack = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_req", 32'(bus_req), 0);
        check("rst_ld", load_data, 0);
        check("rst_outs", {bus_addr[15:0], bus_wdata[7:0], bus_be, bus_we, error, load_mdr, 1'b0}, 0);
        @(negedge clk);
        rst = 1'b1;

        // LW at 0x100, ack on the third request cycle.
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        check("lw_req", 32'(bus_req), 1);
        check("lw_busy", 32'(busy), 1);
        check("lw_addr", bus_addr, 32'h0000_0100);
        check("lw_be", 32'(bus_be), 32'hF);
        check("lw_we", 32'(bus_we), 0);
        complete(2, 32'h1234_5678);
        check("lw_done", 32'(done), 1);
        check("lw_err", 32'(error), 0);
        check("lw_mdr", 32'(load_mdr), 1);
        check("lw_data", load_data, 32'h1234_5678);
        check("lw_req_drop", 32'(bus_req), 0);
        @(negedge clk);
        check("lw_done_pulse", 32'(done), 0);
        check("lw_mdr_pulse", 32'(load_mdr), 0);
        check("lw_idle", 32'(busy), 0);

        load_case("lb", 3'b000, 32'h0000_0203, 32'h80AA_55CC, 4'b1000, 32'hFFFF_FF80);
        load_case("lbu", 3'b100, 32'h0000_0203, 32'h80AA_55CC, 4'b1000, 32'h0000_0080);
        load_case("lh", 3'b001, 32'h0000_0202, 32'h80AA_55CC, 4'b1100, 32'hFFFF_80AA);
        load_case("lhu", 3'b101, 32'h0000_0000, 32'h80AA_55CC, 4'b0011, 32'h0000_55CC);
        load_case("lb1", 3'b000, 32'h0000_0001, 32'h80AA_55CC, 4'b0010, 32'h0000_0055);

        // SH at 0x302: upper lanes, halfword replicated; load_data untouched.
        issue(1'b1, 3'b001, 32'h0000_0302, 32'h0000_BEEF);
        check("sh_we", 32'(bus_we), 1);
        check("sh_be", 32'(bus_be), 32'hC);
        check("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        check("sh_addr", bus_addr, 32'h0000_0300);
        complete(1, 32'h1111_1111);
        check("sh_done", 32'(done), 1);
        check("sh_mdr", 32'(load_mdr), 0);
        check("sh_err", 32'(error), 0);
        check("sh_ld_keep", load_data, 32'h0000_0055);

        issue(1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5);
        check("sb_be", 32'(bus_be), 32'h2);
        check("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        complete(0, 32'h0);
        check("sb_done", 32'(done), 1);

        // Misaligned LW: immediate error, no bus activity.
        issue(1'b0, 3'b010, 32'h0000_1001, 32'h0);
        check("mis_done", 32'(done), 1);
        check("mis_err", 32'(error), 1);
        check("mis_req", 32'(bus_req), 0);
        check("mis_mdr", 32'(load_mdr), 0);
        check("mis_ld_keep", load_data, 32'h0000_0055);
        @(negedge clk);
        check("mis_idle", 32'(busy), 0);
        check("mis_done_pulse", 32'(done), 0);

        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
        check("f3_bad_err", 32'(error), 1);
        check("f3_bad_req", 32'(bus_req), 0);
        issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
        check("sbu_bad_err", 32'(error), 1);

        // start during ACCESS is ignored; ack in IDLE is ignored.
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        start = 1'b1; addr = 32'h0000_0080; mem_write = 1'b1;
        @(negedge clk);
        start = 1'b0; mem_write = 1'b0;
        check("ign_start_addr", bus_addr, 32'h0000_0040);
        check("ign_start_we", 32'(bus_we), 0);
        complete(0, 32'hA5A5_0F0F);
        check("ign_start_data", load_data, 32'hA5A5_0F0F);
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("ack_idle_busy", 32'(busy), 0);
        check("ack_idle_done", 32'(done), 0);

        // Reset mid-ACCESS.
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        check("mid_req", 32'(bus_req), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus_req), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ld", load_data, 0);
        @(negedge clk);
        check("mid_rst_done", 32'(done), 0);
        rst = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        complete(1, 32'hCAFE_F00D);
        check("post_rst_mdr", 32'(load_mdr), 1);
        check("post_rst_data", load_data, 32'hCAFE_F00D);

`ifdef MEM_TIMEOUT_EN
        issue(1'b0, 3'b010, 32'h0000_0600, 32'h0);
        for (int unsigned i = 0; i < 4; i++) begin
            check("to_req", 32'(bus_req), 1);
            @(negedge clk);
        end
        check("to_req_drop", 32'(bus_req), 0);
        check("to_done", 32'(done), 1);
        check("to_err", 32'(error), 1);
        check("to_mdr", 32'(load_mdr), 0);
        check("to_ld_keep", load_data, 32'hCAFE_F00D);
        issue(1'b0, 3'b010, 32'h0000_0604, 32'h0);
        complete(3, 32'h0BAD_C0DE);
        check("to_last_err", 32'(error), 0);
        check("to_last_mdr", 32'(load_mdr), 1);
        check("to_last_data", load_data, 32'h0BAD_C0DE);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
